// File: rtl/dmem_block_responder.sv
// Block refill/writeback responder below the data cache: one 128-bit access at a time,
// fixed BUSY latency, single DONE completion cycle, plus read/write transaction counters.
module dmem_block_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_address,
  input  logic [127:0] mem_writedata,
  output logic [127:0] mem_readdata,
  output logic         mem_busywait,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
);

  // state | meaning
  // IDLE  | waiting for a request; latches op/address/data on the first request edge
  // BUSY  | counting down the access latency; access performed when cnt reaches 0
  // DONE  | completion cycle: write committed / read data valid, busywait low
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          op_write;
  logic [AW-1:0] addr_q;
  logic [127:0]  wdata_q;
  logic [127:0]  mem [DEPTH];
  logic          access;

  // Upper address bits alias onto the same block and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[27:AW];

  assign access = (state == BUSY) && (cnt == 4'd0);

  // Held low in reset so every output reads 0 while reset is asserted.
  assign mem_busywait = reset & (mem_read | mem_write) & (state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_write     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_readdata <= '0;
      read_count   <= '0;
      write_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            op_write <= mem_write;
            addr_q   <= mem_address[AW-1:0];
            wdata_q  <= mem_writedata;
            cnt      <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_write) begin
              write_count <= write_count + 32'd1;
            end else begin
              mem_readdata <= mem[addr_q];
              read_count   <= read_count + 32'd1;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; reset forces IDLE asynchronously, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (access && op_write) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: expected read data is queued at request time
// and compared in the DONE cycle, along with busywait length and counters.
module tb_dmem_block_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic         mem_busywait;
  logic [31:0]  read_count, write_count;

  logic         l1_read, l1_write;
  logic [27:0]  l1_address;
  logic [127:0] l1_writedata, l1_readdata;
  logic         l1_busywait;
  logic [31:0]  l1_read_count, l1_write_count;

  always #5 clk = ~clk;

  dmem_block_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .read_count(read_count), .write_count(write_count)
  );

  dmem_block_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk(clk), .reset(reset), .mem_read(l1_read), .mem_write(l1_write),
    .mem_address(l1_address), .mem_writedata(l1_writedata),
    .mem_readdata(l1_readdata), .mem_busywait(l1_busywait),
    .read_count(l1_read_count), .write_count(l1_write_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] ref_mem [int];
  logic [127:0] ref_rdata = '0;
  logic [31:0]  ref_rc = '0;
  logic [31:0]  ref_wc = '0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] BLK0 = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] BLK_A = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [127:0] BLK_B = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
  localparam logic [127:0] BLK_C = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
  localparam logic [127:0] BLK_D = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;
  localparam logic [127:0] BLK_E = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge while the DUT is IDLE.
  task automatic start_req(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
    int idx;
    idx = int'(a[7:0]);
    if (wr) begin
      ref_mem[idx] = d;
      ref_wc = ref_wc + 32'd1;
    end else begin
      ref_rdata = ref_mem[idx];
      ref_rc = ref_rc + 32'd1;
    end
    exp_q.push_back(ref_rdata);
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = a;
    mem_writedata = d;
  endtask

  // Counts busywait cycles up to DONE, checks the completion, then steps into the next cycle.
  task automatic finish_req(input string tag, input bit keep_read);
    int busy;
    logic [127:0] e;
    busy = 0;
    while (1) begin
      @(negedge clk);
      if (!mem_busywait) break;
      busy++;
      if (busy > 40) break;
    end
    check({tag, " busy_cycles"}, 128'(busy), 128'(LAT + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, " readdata"}, mem_readdata, e);
    check({tag, " read_count"}, 128'(read_count), 128'(ref_rc));
    check({tag, " write_count"}, 128'(write_count), 128'(ref_wc));
    mem_write = 1'b0;
    mem_read  = keep_read;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_writedata = '0;
    l1_read = 1'b0; l1_write = 1'b0; l1_address = '0; l1_writedata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst readdata", mem_readdata, '0);
    check("rst read_count", 128'(read_count), '0);
    check("rst write_count", 128'(write_count), '0);
    check("rst busywait", 128'(mem_busywait), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    start_req(1'b0, 1'b1, 28'h0000005, BLK0);  finish_req("wr5", 1'b0);
    start_req(1'b1, 1'b0, 28'h0000005, '0);    finish_req("rd5", 1'b0);

    start_req(1'b0, 1'b1, 28'h0000105, BLK_A); finish_req("wr105", 1'b0);
    start_req(1'b1, 1'b0, 28'h0000005, '0);    finish_req("rd_alias", 1'b0);

    // Reset in BUSY cycle c2 of a write of B over A at address 7.
    start_req(1'b0, 1'b1, 28'h0000007, BLK_A); finish_req("wr7", 1'b0);
    mem_write = 1'b1; mem_address = 28'h0000007; mem_writedata = BLK_B;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("inrst readdata", mem_readdata, '0);
    check("inrst read_count", 128'(read_count), '0);
    check("inrst write_count", 128'(write_count), '0);
    check("inrst busywait", 128'(mem_busywait), '0);
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ref_rc = '0; ref_wc = '0; ref_rdata = '0;
    @(posedge clk); #1;
    start_req(1'b1, 1'b0, 28'h0000007, '0);    finish_req("rd_after_rst", 1'b0);

    // Request dropped at c1 with the address changed.
    mem_write = 1'b1; mem_address = 28'h0000009; mem_writedata = BLK_C;
    ref_mem[9] = BLK_C; ref_wc = ref_wc + 32'd1;
    @(negedge clk);
    check("drop busy_c0", 128'(mem_busywait), 128'(1));
    @(posedge clk); #1;
    mem_write = 1'b0; mem_address = 28'h0000033; mem_writedata = '0;
    @(negedge clk);
    check("drop busy_c1", 128'(mem_busywait), '0);
    repeat (5) @(posedge clk);
    #1;
    check("drop write_count", 128'(write_count), 128'(ref_wc));
    start_req(1'b1, 1'b0, 28'h0000009, '0);    finish_req("rd9", 1'b0);

    // Read+write together is a write; read held through DONE starts the next transaction.
    start_req(1'b1, 1'b1, 28'h0000020, BLK_D); finish_req("rw_both", 1'b1);
    start_req(1'b1, 1'b0, 28'h0000020, '0);    finish_req("held_rd", 1'b0);

    // Counter wrap.
    force dut.read_count = 32'hFFFF_FFFF;
    #1;
    release dut.read_count;
    ref_rc = 32'hFFFF_FFFF;
    start_req(1'b1, 1'b0, 28'h0000005, '0);    finish_req("wrap", 1'b0);
    check("wrap zero", 128'(read_count), '0);

    // Minimum latency instance.
    l1_write = 1'b1; l1_address = 28'h0000003; l1_writedata = BLK_E;
    busy = 0;
    while (1) begin
      @(negedge clk);
      if (!l1_busywait) break;
      busy++;
      if (busy > 40) break;
    end
    check("lat1 wr busy_cycles", 128'(busy), 128'(2));
    check("lat1 write_count", 128'(l1_write_count), 128'(1));
    l1_write = 1'b0;
    @(posedge clk); #1;
    l1_read = 1'b1;
    busy = 0;
    while (1) begin
      @(negedge clk);
      if (!l1_busywait) break;
      busy++;
      if (busy > 40) break;
    end
    check("lat1 rd busy_cycles", 128'(busy), 128'(2));
    check("lat1 readdata", l1_readdata, BLK_E);
    check("lat1 read_count", 128'(l1_read_count), 128'(1));
    l1_read = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
